// File: rtl/life_pkg.sv
// Shared types and default geometry for the Game-of-Life sequencer and cell array.
package life_pkg;

  typedef enum logic [2:0] {
    S_LOAD,
    S_WAIT,
    S_COMPUTE,
    S_COMMIT,
    S_HALT
  } life_state_t;

  localparam int unsigned LIFE_ROWS  = 8;
  localparam int unsigned LIFE_GEN_W = 16;

  // Datapath is owned by the sequencer in these states.
  function automatic logic is_busy(input life_state_t s);
    return (s == S_LOAD) || (s == S_COMPUTE) || (s == S_COMMIT);
  endfunction

endpackage

// File: rtl/life_tick_prescaler.sv
// Free-run pacing counter: counts while enabled, holds otherwise, flags its terminal count.
module life_tick_prescaler #(
  parameter int unsigned TICK_PERIOD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tc
);

  localparam int unsigned CNT_W = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(TICK_PERIOD - 1);

  logic [CNT_W-1:0] r_count;

  assign o_tc = (r_count == LastCnt);

  // Clear wins over enable so the exit cycle always leaves the counter at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_tc ? '0 : r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/life_sequencer.sv
// Control FSM sequencing seed load, paced compute/commit generations and stable-board halt.
module life_sequencer
  import life_pkg::*;
#(
  parameter int unsigned ROWS           = LIFE_ROWS,
  parameter int unsigned TICK_PERIOD    = 4,
  parameter int unsigned COMPUTE_CYCLES = 1,
  parameter int unsigned GEN_W          = LIFE_GEN_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run_en,
  input  logic                    step_req,
  input  logic                    load_req,
  input  logic                    array_changed,
  output logic                    load_en,
  output logic [$clog2(ROWS)-1:0] load_row,
  output logic                    compute_en,
  output logic                    commit_en,
  output logic [GEN_W-1:0]        generation,
  output logic                    busy,
  output logic                    halted
);

  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned CC_W  = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;
  localparam logic [ROW_W-1:0] LastRow = ROW_W'(ROWS - 1);
  localparam logic [CC_W-1:0]  LastCc  = CC_W'(COMPUTE_CYCLES - 1);

  life_state_t      r_state, w_state_d;
  logic [ROW_W-1:0] r_load_row, w_load_row_d;
  logic [GEN_W-1:0] r_gen, w_gen_d;
  logic [CC_W-1:0]  r_cc, w_cc_d;
  logic             r_pending, w_pending_d;
  logic             w_presc_en, w_presc_clr, w_presc_tc;

  life_tick_prescaler #(
    .TICK_PERIOD(TICK_PERIOD)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_presc_en),
    .i_clr(w_presc_clr),
    .o_tc (w_presc_tc)
  );

  always_comb begin
    w_state_d    = r_state;
    w_load_row_d = r_load_row;
    w_gen_d      = r_gen;
    w_cc_d       = r_cc;
    w_pending_d  = r_pending;
    w_presc_en   = 1'b0;
    w_presc_clr  = 1'b0;
    unique case (r_state)
      S_LOAD: begin
        w_pending_d = 1'b0;
        if (load_req) begin
          w_load_row_d = '0;
        end else if (r_load_row == LastRow) begin
          w_load_row_d = '0;
          w_gen_d      = '0;
          w_state_d    = S_WAIT;
        end else begin
          w_load_row_d = r_load_row + ROW_W'(1);
        end
      end
      S_WAIT: begin
        w_presc_en = run_en;
        if (load_req) begin
          w_presc_clr  = 1'b1;
          w_load_row_d = '0;
          w_state_d    = S_LOAD;
        end else if (step_req || (run_en && w_presc_tc)) begin
          w_presc_clr = 1'b1;
          w_cc_d      = '0;
          w_state_d   = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (load_req) w_pending_d = 1'b1;
        if (r_cc == LastCc) begin
          w_cc_d    = '0;
          w_state_d = S_COMMIT;
        end else begin
          w_cc_d = r_cc + CC_W'(1);
        end
      end
      S_COMMIT: begin
        w_gen_d = r_gen + GEN_W'(1);
        // A reload requested during the generation takes effect only after it commits.
        if (r_pending || load_req) begin
          w_pending_d  = 1'b0;
          w_load_row_d = '0;
          w_state_d    = S_LOAD;
        end else if (!array_changed) begin
          w_state_d = S_HALT;
        end else begin
          w_state_d = S_WAIT;
        end
      end
      S_HALT: begin
        if (load_req) begin
          w_load_row_d = '0;
          w_state_d    = S_LOAD;
        end
      end
      default: begin
        w_load_row_d = '0;
        w_state_d    = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_LOAD;
      r_load_row <= '0;
      r_gen      <= '0;
      r_cc       <= '0;
      r_pending  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_load_row <= w_load_row_d;
      r_gen      <= w_gen_d;
      r_cc       <= w_cc_d;
      r_pending  <= w_pending_d;
    end
  end

  assign load_en    = (r_state == S_LOAD);
  assign load_row   = r_load_row;
  assign compute_en = (r_state == S_COMPUTE);
  assign commit_en  = (r_state == S_COMMIT);
  assign generation = r_gen;
  assign busy       = is_busy(r_state);
  assign halted     = (r_state == S_HALT);

endmodule

// File: tb/tb_life_sequencer.sv
// Directed bench for life_sequencer with a generation scoreboard popped on each commit.
module tb_life_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run_en = 1'b0;
  logic        step_req = 1'b0;
  logic        load_req = 1'b0;
  logic        array_changed = 1'b1;
  logic        load_en;
  logic [2:0]  load_row;
  logic        compute_en;
  logic        commit_en;
  logic [15:0] generation;
  logic        busy;
  logic        halted;

  life_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .run_en       (run_en),
    .step_req     (step_req),
    .load_req     (load_req),
    .array_changed(array_changed),
    .load_en      (load_en),
    .load_row     (load_row),
    .compute_en   (compute_en),
    .commit_en    (commit_en),
    .generation   (generation),
    .busy         (busy),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err = 0;
  int exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sb_pop_check(input string tag);
    logic [31:0] e;
    chk({tag, "_sb_depth"}, exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(tag, generation, e);
    end
  endtask

  task automatic wait_commit(input string tag, input int bound, output int at);
    bit seen = 0;
    at = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (commit_en) begin
        seen = 1;
        at = cyc;
        break;
      end
    end
    chk({tag, "_commit_seen"}, seen, 1);
    if (seen) begin
      @(posedge clk);
      #1;
      sb_pop_check(tag);
    end
  endtask

  task automatic check_load(input string tag);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_row%0d", tag, i), {load_en, load_row}, {1'b1, 3'(i)});
      @(negedge clk);
    end
    chk({tag, "_done_busy"}, {load_en, busy}, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, t1, t2, n;

    // Reset decode
    #12;
    chk("rst_flags", {load_en, busy, halted, compute_en, commit_en}, 5'b11000);
    chk("rst_gen", generation, 0);
    chk("rst_row", load_row, 0);
    @(negedge clk);
    rst = 1'b1;
    check_load("load1");
    chk("load1_gen", generation, 0);

    // Free run: one generation every TICK_PERIOD+COMPUTE_CYCLES+1 = 6 cycles
    run_en = 1'b1;
    exp_q.push_back(1);
    wait_commit("run1", 20, t0);
    exp_q.push_back(2);
    wait_commit("run2", 20, t1);
    chk("run_period1", t1 - t0, 6);
    exp_q.push_back(3);
    wait_commit("run3", 20, t2);
    chk("run_period2", t2 - t1, 6);
    run_en = 1'b0;

    // Single step: one compute cycle, one commit
    @(negedge clk);
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    chk("step_compute", {compute_en, commit_en}, 2'b10);
    @(negedge clk);
    chk("step_commit", {compute_en, commit_en}, 2'b01);
    exp_q.push_back(4);
    @(posedge clk);
    #1;
    sb_pop_check("step_gen");
    n = 0;
    repeat (8) begin
      @(negedge clk);
      n += int'(compute_en) + int'(commit_en);
    end
    chk("step_idle", n, 0);

    // Prescaler holds its count while run_en is low
    run_en = 1'b1;
    repeat (2) @(negedge clk);
    run_en = 1'b0;
    repeat (5) @(negedge clk);
    chk("hold_idle", {busy, compute_en}, 2'b00);
    run_en = 1'b1;
    @(negedge clk);
    chk("hold_pre", compute_en, 0);
    @(negedge clk);
    chk("hold_resume", compute_en, 1);
    exp_q.push_back(5);
    wait_commit("hold", 5, t0);
    run_en = 1'b0;

    // Stable board halts; run/step ignored; load_req exits
    array_changed = 1'b0;
    run_en = 1'b1;
    exp_q.push_back(6);
    wait_commit("halt", 20, t0);
    chk("halt_flag", {halted, busy}, 2'b10);
    array_changed = 1'b1;
    @(negedge clk);
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      n += int'(compute_en);
    end
    chk("halt_no_compute", n, 0);
    chk("halt_stays", halted, 1);
    load_req = 1'b1;
    run_en = 1'b0;
    @(negedge clk);
    load_req = 1'b0;
    chk("halt_exit", {halted, load_en}, 2'b01);
    check_load("load2");
    chk("load2_gen", generation, 0);

    // load_req during COMPUTE: commit first, then reload
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    chk("pend_compute", compute_en, 1);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    chk("pend_commit", commit_en, 1);
    exp_q.push_back(1);
    @(posedge clk);
    #1;
    sb_pop_check("pend_gen");
    chk("pend_to_load", {load_en, load_row}, 4'b1000);
    @(negedge clk);
    check_load("load3");
    chk("load3_gen", generation, 0);

    // Async reset mid-COMPUTE
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    exp_q.push_back(1);
    wait_commit("pre_rst", 5, t0);
    @(negedge clk);
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    chk("rst_mid_compute", compute_en, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_flags", {compute_en, load_en, busy}, 3'b011);
    chk("rst_mid_gen", generation, 0);
    chk("rst_mid_row", load_row, 0);
    @(negedge clk);
    rst = 1'b1;
    check_load("load4");

    // load_req during LOAD restarts at row 0
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("restart_row3", load_row, 3);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    check_load("load5");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
